// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage PC controller bus: fetched-instruction info, M/W redirect inputs,
// and the PC/prediction outputs that travel down the pipe.
interface fetch_pc_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              f_valid_i;
    logic [3:0]        f_icode_i;
    logic [ADDR_W-1:0] f_valC_i;
    logic [ADDR_W-1:0] f_valP_i;
    logic              stall_i;
    logic              M_jmp_i;
    logic              M_Cnd_i;
    logic [ADDR_W-1:0] M_valA_i;
    logic              W_ret_i;
    logic [ADDR_W-1:0] W_valM_i;
    logic              W_rethit_i;
    logic [ADDR_W-1:0] W_retpred_i;
    logic [ADDR_W-1:0] f_pc_o;
    logic              ret_hit_o;
    logic [ADDR_W-1:0] ret_pred_o;
    logic              redirect_o;
    logic              halted_o;

    modport master (
        input  f_valid_i, f_icode_i, f_valC_i, f_valP_i, stall_i,
        input  M_jmp_i, M_Cnd_i, M_valA_i,
        input  W_ret_i, W_valM_i, W_rethit_i, W_retpred_i,
        output f_pc_o, ret_hit_o, ret_pred_o, redirect_o, halted_o
    );

    modport slave (
        output f_valid_i, f_icode_i, f_valC_i, f_valP_i, stall_i,
        output M_jmp_i, M_Cnd_i, M_valA_i,
        output W_ret_i, W_valM_i, W_rethit_i, W_retpred_i,
        input  f_pc_o, ret_hit_o, ret_pred_o, redirect_o, halted_o
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Y86-64 fetch PC controller: registered predicted PC, return-address stack,
// and M/W redirect handling with RET_WAIT / HALT freeze states.
//
// state    | meaning
// RUN      | fetching along the predicted path
// RET_WAIT | ret fetched with empty RAS; frozen until a redirect supplies the target
// HALT     | halt fetched (possibly speculative); frozen until a redirect
module fetch_pc_ctrl #(
    parameter int                ADDR_W    = 64,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    fetch_pc_ctrl_if.master bus
);
    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

    typedef enum logic [1:0] {RUN, RET_WAIT, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;
    logic [ADDR_W-1:0] target, f_pc, ras_top, ret_pred;
    logic              w_redir, m_redir, redirect, consume;
    logic              ras_empty, push, pop, ret_hit;

    // Redirects are masked during reset so the outputs show the reset PC
    assign w_redir  = bus.W_ret_i && (!bus.W_rethit_i || (bus.W_valM_i != bus.W_retpred_i));
    assign m_redir  = bus.M_jmp_i && !bus.M_Cnd_i;
    assign redirect = rst_n_i && (w_redir || m_redir);
    assign target   = w_redir ? bus.W_valM_i : bus.M_valA_i;
    assign f_pc     = redirect ? target : pred_pc_q;
    assign consume  = rst_n_i && bus.f_valid_i && !bus.stall_i && (state_q == RUN || redirect);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RUN;
            pred_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pred_pc_q <= pred_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect)
            state_d = RUN;
        if (consume) begin
            if (bus.f_icode_i == IRET && ras_empty)
                state_d = RET_WAIT;
            else if (bus.f_icode_i == IHALT)
                state_d = HALT;
        end
    end

    // A ret/halt that has to freeze parks on its own address, so the frozen
    // fetch PC is the instruction itself even when it arrived via redirect.
    always_comb begin
        pred_pc_d = redirect ? target : pred_pc_q;
        push      = 1'b0;
        pop       = 1'b0;
        ret_hit   = 1'b0;
        ret_pred  = '0;
        if (consume) begin
            case (bus.f_icode_i)
                IJXX:  pred_pc_d = bus.f_valC_i;
                ICALL: begin
                    pred_pc_d = bus.f_valC_i;
                    push      = 1'b1;
                end
                IRET: begin
                    if (!ras_empty) begin
                        pred_pc_d = ras_top;
                        pop       = 1'b1;
                        ret_hit   = 1'b1;
                        ret_pred  = ras_top;
                    end else begin
                        pred_pc_d = f_pc;
                    end
                end
                IHALT:   pred_pc_d = f_pc;
                default: pred_pc_d = bus.f_valP_i;
            endcase
        end
    end

    assign bus.f_pc_o     = f_pc;
    assign bus.redirect_o = redirect;
    assign bus.ret_hit_o  = ret_hit;
    assign bus.ret_pred_o = ret_pred;
    assign bus.halted_o   = (state_q == HALT);

    generate
        if (RAS_DEPTH > 0) begin : g_ras
            localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
            localparam int CNT_W = $clog2(RAS_DEPTH + 1);

            logic [ADDR_W-1:0] mem [RAS_DEPTH];
            logic [PTR_W-1:0]  ptr_q, ptr_inc, ptr_dec;
            logic [CNT_W-1:0]  cnt_q, cnt_base;

            // ptr_q is the next write slot; the top of stack sits one below it
            assign ptr_inc   = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
            assign ptr_dec   = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - 1'b1;
            assign cnt_base  = redirect ? '0 : cnt_q;
            assign ras_empty = (cnt_base == '0);
            assign ras_top   = mem[ptr_dec];

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    ptr_q <= '0;
                    cnt_q <= '0;
                end else if (push) begin
                    ptr_q <= ptr_inc;
                    cnt_q <= (cnt_base == CNT_W'(RAS_DEPTH)) ? cnt_base : cnt_base + 1'b1;
                end else if (pop) begin
                    ptr_q <= ptr_dec;
                    cnt_q <= cnt_base - 1'b1;
                end else begin
                    cnt_q <= cnt_base;
                end
            end

            always_ff @(posedge clk_i) begin
                if (push)
                    mem[ptr_q] <= bus.f_valP_i;
            end
        end else begin : g_no_ras
            assign ras_empty = 1'b1;
            assign ras_top   = '0;
        end
    endgenerate
endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Sequential fetch-stage PC controller for the Y86-64 pipeline, replacing purely combinational next-PC selection. Holds the predicted PC in a register, predicts `ret` targets with a parametrised return-address stack (RAS), and redirects fetch on mispredicted jumps (M stage) and mispredicted returns (W stage). Tracks halt and ret-wait states so fetch freezes cleanly and recovers on redirect. Sits between the instruction memory/decoder (fetch) and the F pipeline register.

## Interface
Parameters:
- `ADDR_W`, 64, PC/address width
- `RAS_DEPTH`, 4, RAS entries; 0 disables the RAS, so every `ret` waits for W
- `RESET_PC`, 0, PC after reset

Ports:
- `clk_i`  in  1  clock, all state on rising edge
- `rst_n_i`  in  1  asynchronous, active-low reset
- `f_valid_i`  in  1  fetched instruction at `f_pc_o` is valid this cycle
- `f_icode_i`  in  4  icode of fetched instruction (`define.v` codes)
- `f_valC_i`  in  ADDR_W  constant/destination of fetched instruction
- `f_valP_i`  in  ADDR_W  fall-through address of fetched instruction
- `stall_i`  in  1  F stall from pipeline control; fetch not consumed
- `M_jmp_i`  in  1  conditional jump in M stage
- `M_Cnd_i`  in  1  jump condition outcome in M
- `M_valA_i`  in  ADDR_W  fall-through PC carried with the jump
- `W_ret_i`  in  1  `ret` in W stage
- `W_valM_i`  in  ADDR_W  actual return address
- `W_rethit_i`  in  1  that `ret` was RAS-predicted
- `W_retpred_i`  in  ADDR_W  address it was predicted to
- `f_pc_o`  out  ADDR_W  PC to fetch this cycle
- `ret_hit_o`  out  1  current `ret` fetch predicted by RAS (carried down pipe)
- `ret_pred_o`  out  ADDR_W  RAS prediction for current `ret` (carried down pipe)
- `redirect_o`  out  1  redirect active this cycle
- `halted_o`  out  1  state is HALT

## Operation
- Redirect sources, highest priority first: W (`W_ret_i` and (`!W_rethit_i` or `W_valM_i != W_retpred_i`)) -> target `W_valM_i`; M (`M_jmp_i && !M_Cnd_i`) -> target `M_valA_i`. W is older, so W wins when both fire.
- `f_pc_o` = redirect target if redirect, else `predPC_q`. `redirect_o` = either source.
- States: RUN, RET_WAIT, HALT. Any redirect forces next state RUN and clears RAS (count=0) before this cycle's push/pop.
- Consumed fetch = `f_valid_i && !stall_i && (state==RUN || redirect)`. On consumed fetch, by `f_icode_i`:
  - IJXX: `predPC_q <= f_valC_i` (predict taken)
  - ICALL: `predPC_q <= f_valC_i`; push `f_valP_i`
  - IRET: RAS non-empty -> `predPC_q <=` top, pop, `ret_hit_o=1`, `ret_pred_o`=top; empty -> RET_WAIT, `predPC_q` held, `ret_hit_o=0`
  - IHALT: HALT, `predPC_q <= f_pc_o`
  - others: `predPC_q <= f_valP_i`
- Stalled with redirect: `predPC_q <=` target, no RAS op. Stalled without redirect, or not-valid fetch: all state held.
- RET_WAIT/HALT without redirect: `f_pc_o`, `predPC_q`, RAS held; no fetch consumed. Exit only through redirect (W ret miss resolves RET_WAIT; a speculative HALT is cancelled by M or W redirect).
- RAS: circular, `RAS_DEPTH` entries, count saturates at `RAS_DEPTH`; push when full overwrites oldest. Pop when empty is not possible (routes to RET_WAIT). `RAS_DEPTH=0`: stack logic absent, always empty.
- Address compare is full `ADDR_W`; no arithmetic on PCs.

## Timing
- Reset (async, `rst_n_i`=0): `predPC_q=RESET_PC`, state RUN, RAS empty; `f_pc_o=RESET_PC`, `redirect_o=0`, `ret_hit_o=0`, `ret_pred_o=0`, `halted_o=0` regardless of other inputs. Reset mid-operation discards all state in that cycle.
- `f_pc_o`, `redirect_o`, `ret_hit_o`, `ret_pred_o`: combinational, same cycle. Redirect target fetched in the redirect cycle (0-cycle redirect latency).
- `predPC_q`, state, RAS: update at rising edge; next-PC latency 1 cycle. `halted_o` registered (state).

## Test plan
- Reset with `RESET_PC=0x100`, NOP fetches `valP` 0x101..: `f_pc_o` 0x100, 0x101, 0x102 on successive cycles; `redirect_o=0`.
- CALL at 0x100 (`valC`=0x200, `valP`=0x109), later RET at 0x200: next PC 0x200, then `f_pc_o`=0x109 with `ret_hit_o=1`, `ret_pred_o`=0x109.
- JXX at 0x10 (`valC`=0x40); next cycle `M_jmp_i=1`, `M_Cnd_i=0`, `M_valA_i`=0x19 with simultaneous W ret miss `W_valM_i`=0x80: `f_pc_o`=0x80 (W wins), RAS count 0.
- `RAS_DEPTH=0`, RET fetched: state RET_WAIT, `f_pc_o` frozen 3 cycles; `W_ret_i=1`, `W_rethit_i=0`, `W_valM_i`=0x300 -> `f_pc_o`=0x300, RUN next cycle.
- HALT fetched at 0x50 on wrong path: `halted_o=1` next cycle, `f_pc_o`=0x50 held; M mispredict `M_valA_i`=0x60 -> `f_pc_o`=0x60, `halted_o=0` next cycle.
- `RAS_DEPTH=2`, three CALLs pushing 0xA,0xB,0xC, then three RETs: predictions 0xC, 0xB, then RET_WAIT; `stall_i=1` on a CALL leaves RAS unchanged.
